// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types, widths and carry-save helper for the dot-product MAC
//
// Contents:
//   state_t         FSM states IDLE/RUN/DRAIN/DONE
//   OP_W, PROD_W    operand and product widths (8, 16)
//   DEFAULT_N_TERMS default operand pairs per dot product
//   DEFAULT_ACC_W   product width plus headroom for DEFAULT_N_TERMS full-scale terms
//   csa()           3:2 carry-save compressor; [0] = sum row, [1] = carry row (pre-shifted)
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int OP_W            = 8;
    localparam int PROD_W          = 16;
    localparam int DEFAULT_N_TERMS = 8;
    localparam int DEFAULT_ACC_W   = PROD_W + $clog2(DEFAULT_N_TERMS);

    function automatic logic [1:0][PROD_W-1:0] csa(
        input logic [PROD_W-1:0] x,
        input logic [PROD_W-1:0] y,
        input logic [PROD_W-1:0] z
    );
        logic [PROD_W-1:0] s;
        logic [PROD_W-1:0] c;
        s = x ^ y ^ z;
        c = (x & y) | (x & z) | (y & z);
        return {c << 1, s};
    endfunction

endpackage

// File: rtl/wallace_multiplier.sv
// rtl/wallace_multiplier.sv - combinational 8x8 unsigned Wallace-tree multiplier
//
// Ports:
//   a  in  8   multiplicand
//   b  in  8   multiplier
//   p  out 16  a * b
module wallace_multiplier
    import mac_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] p
);

    logic [PROD_W-1:0] pp [OP_W];

    for (genvar i = 0; i < OP_W; i++) begin : g_pp
        assign pp[i] = b[i] ? (PROD_W'(a) << i) : '0;
    end

    // Reduction tree 8 -> 6 -> 4 -> 3 -> 2 rows, then one carry-propagate add.
    // Carries leaving bit 15 are dropped; the true product always fits in 16 bits.
    logic [1:0][PROD_W-1:0] l1a, l1b, l2a, l2b, l3, l4;

    assign l1a = csa(pp[0], pp[1], pp[2]);
    assign l1b = csa(pp[3], pp[4], pp[5]);
    assign l2a = csa(l1a[0], l1a[1], l1b[0]);
    assign l2b = csa(l1b[1], pp[6], pp[7]);
    assign l3  = csa(l2a[0], l2a[1], l2b[0]);
    assign l4  = csa(l3[0], l3[1], l2b[1]);

    assign p = l4[0] + l4[1];

endmodule

// File: rtl/wallace_dot_mac.sv
// rtl/wallace_dot_mac.sv - streaming dot-product accumulator around wallace_multiplier
//
// Build option: SATURATE_EN - accumulator clamps at all-ones instead of wrapping.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   start      in   1      begin a new dot product (IDLE only)
//   a, b       in   8      unsigned operand pair
//   in_valid   in   1      a/b valid
//   in_ready   out  1      operand pair accepted this cycle when in_valid
//   acc        out  ACC_W  final sum, valid while out_valid
//   out_valid  out  1      result available, held until out_ready
//   out_ready  in   1      consumer takes the result
//   busy       out  1      run or drain in progress
module wallace_dot_mac
    import mac_pkg::*;
#(
    parameter int N_TERMS = DEFAULT_N_TERMS,
    parameter int ACC_W   = DEFAULT_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int               CNT_W     = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N_TERMS - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [OP_W-1:0]   a_in, b_in, a_op, b_op;
    logic              v0, v1, v2;
    logic [PROD_W-1:0] prod, prod_q;
    logic [ACC_W-1:0]  acc_next;
    logic              begin_run, accept, last_accept, drain_done;

    assign begin_run   = (state == IDLE) && start;
    assign accept      = (state == RUN) && in_valid && in_ready;
    assign last_accept = accept && (cnt == LAST_IDX);
    // Last product lands in acc on this edge: it sits in prod_q and nothing is behind it.
    assign drain_done  = (state == DRAIN) && v2 && !v1 && !v0;
    assign busy        = (state == RUN) || (state == DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)       state_nxt = RUN;
            RUN:     if (last_accept) state_nxt = DRAIN;
            DRAIN:   if (drain_done)  state_nxt = DONE;
            DONE:    if (out_ready)   state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Accepted pairs pass an input register before the operand register so the
    // multiplier is fed register-to-register, isolated from upstream timing.
    wallace_multiplier u_mult (
        .a (a_op),
        .b (b_op),
        .p (prod)
    );

`ifdef SATURATE_EN
    logic [ACC_W:0] acc_sum;
    assign acc_sum  = {1'b0, acc} + (ACC_W + 1)'(prod_q);
    assign acc_next = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
`else
    assign acc_next = acc + ACC_W'(prod_q);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            a_in      <= '0;
            b_in      <= '0;
            a_op      <= '0;
            b_op      <= '0;
            prod_q    <= '0;
            v0        <= 1'b0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            acc       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            v0 <= accept;
            v1 <= v0;
            v2 <= v1;
            if (accept) begin
                a_in <= a;
                b_in <= b;
                cnt  <= cnt + 1'b1;
            end
            if (v0) begin
                a_op <= a_in;
                b_op <= b_in;
            end
            if (v1) prod_q <= prod;

            if (begin_run) begin
                cnt      <= '0;
                acc      <= '0;
                in_ready <= 1'b1;
            end else begin
                if (last_accept) in_ready <= 1'b0;
                if (v2)          acc      <= acc_next;
            end

            if (drain_done)                       out_valid <= 1'b1;
            else if (state == DONE && out_ready)  out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wallace_dot_mac.sv
// tb/tb_wallace_dot_mac.sv - directed self-checking bench for wallace_dot_mac
module tb_wallace_dot_mac;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, busy;
    logic [18:0] acc;
    logic        in_ready16, out_valid16, busy16;
    logic [15:0] acc16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wallace_dot_mac dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .acc       (acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    wallace_dot_mac #(.N_TERMS(8), .ACC_W(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready16),
        .acc       (acc16),
        .out_valid (out_valid16),
        .out_ready (out_ready),
        .busy      (busy16)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        total++; if (acc !== 19'd0)      begin bad++; $display("FAIL reset_acc got=%0d want=0", acc); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL reset_in_ready got=%0b want=0", in_ready); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (in_ready16 !== 1'b0) begin bad++; $display("FAIL reset_in_ready16 got=%0b want=0", in_ready16); end
        rst = 1'b0;
        tick();
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL idle_busy got=%0b want=0", busy); end
    endtask

    task automatic test_basic_sum;
        do_start();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready got=%0b want=1", in_ready); end
        total++; if (busy !== 1'b1)     begin bad++; $display("FAIL basic_busy got=%0b want=1", busy); end
        for (int i = 1; i <= 8; i++) begin
            a = 8'(i); b = 8'd2; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL basic_ready_drop got=%0b want=0", in_ready); end
        tick();
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%0b want=0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_out_valid got=%0b want=1", out_valid); end
        total++; if (acc !== 19'd72)     begin bad++; $display("FAIL basic_acc got=%0d want=72", acc); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL basic_done_busy got=%0b want=0", busy); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_release got=%0b want=0", out_valid); end
        total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL basic_idle_ready got=%0b want=0", in_ready); end
    endtask

    task automatic test_full_scale;
        logic [15:0] want16;
`ifdef SATURATE_EN
        want16 = 16'd65535;
`else
        want16 = 16'd61448;
`endif
        do_start();
        for (int i = 0; i < 8; i++) begin
            a = 8'd255; b = 8'd255; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        total++; if (out_valid !== 1'b1)  begin bad++; $display("FAIL full_out_valid got=%0b want=1", out_valid); end
        total++; if (acc !== 19'd520200)  begin bad++; $display("FAIL full_acc got=%0d want=520200", acc); end
        total++; if (out_valid16 !== 1'b1) begin bad++; $display("FAIL overflow_out_valid got=%0b want=1", out_valid16); end
        total++; if (acc16 !== want16)    begin bad++; $display("FAIL overflow_acc got=%0d want=%0d", acc16, want16); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (busy16 !== 1'b0)     begin bad++; $display("FAIL overflow_idle_busy got=%0b want=0", busy16); end
    endtask

    task automatic test_bubbles;
        do_start();
        for (int i = 1; i <= 8; i++) begin
            if (i > 1) begin
                in_valid = 1'b0; a = 8'd99; b = 8'd99;
                tick();
            end
            a = 8'(i); b = 8'd2; in_valid = 1'b1;
            tick();
        end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bubble_ready_drop got=%0b want=0", in_ready); end
        a = 8'd200; b = 8'd200; in_valid = 1'b1;
        tick(); tick(); tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bubble_out_valid got=%0b want=1", out_valid); end
        total++; if (acc !== 19'd72)     begin bad++; $display("FAIL bubble_acc got=%0d want=72", acc); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bubble_release got=%0b want=0", out_valid); end
    endtask

    task automatic test_backpressure;
        do_start();
        for (int i = 0; i < 8; i++) begin
            a = 8'd3; b = 8'd4; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++; if (acc !== 19'd96)     begin bad++; $display("FAIL bp_acc cycle=%0d got=%0d want=96", i, acc); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid cycle=%0d got=%0b want=1", i, out_valid); end
            total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL bp_in_ready cycle=%0d got=%0b want=0", i, in_ready); end
            tick();
        end
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%0b want=0", out_valid); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL bp_start_ignored got=%0b want=0", busy); end
        tick();
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL bp_still_idle got=%0b want=0", busy); end
    endtask

    task automatic test_reset_mid_run;
        do_start();
        for (int i = 0; i < 3; i++) begin
            a = 8'd5; b = 8'd5; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        total++; if (acc !== 19'd50)     begin bad++; $display("FAIL midrun_partial got=%0d want=50", acc); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (acc !== 19'd0)      begin bad++; $display("FAIL midrun_acc got=%0d want=0", acc); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL midrun_busy got=%0b want=0", busy); end
        total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL midrun_in_ready got=%0b want=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrun_out_valid got=%0b want=0", out_valid); end
        rst = 1'b0;
        tick();
        do_start();
        for (int i = 0; i < 8; i++) begin
            a = 8'd1; b = 8'd1; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rerun_out_valid got=%0b want=1", out_valid); end
        total++; if (acc !== 19'd8)      begin bad++; $display("FAIL rerun_acc got=%0d want=8", acc); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_full_scale();
        test_bubbles();
        test_backpressure();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
